div32b_iter: RTL and testbench

Iterative 32-bit integer divider for the FL-M32 execute stage, companion to the one-cycle Booth multiplier: it implements the RV32M divide family (DIV, DIVU, REM, REMU) that the multiplier cannot cover. It uses a radix-2 restoring algorithm, producing one quotient bit per cycle. A ready/valid handshake lets the pipeline stall while the block is busy. A flush input discards an in-flight operation.

---
 rtl/div32b_iter.sv | 132 +++++++++++++
 tb/tb_div32b_iter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div32b_iter.sv
// rtl/div32b_iter.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
`timescale 1ns/1ps

module div32b_iter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;        // partial remainder (always < divisor)
  logic [31:0] dvd_q, dvd_d;        // dividend shifts out, quotient shifts in
  logic [31:0] dvs_q, dvs_d;
  logic        op_rem_q, op_rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] result_q, result_d;

  // Accept-time operand conditioning: magnitudes for signed ops, special-case detection.
  // |0x80000000| stays 0x80000000 and is simply treated as unsigned.
  logic        signed_op, s1_neg, s2_neg, div_zero, overflow;
  logic [31:0] abs1, abs2;
  assign signed_op = ~i_op[0];
  assign s1_neg    = signed_op & i_src1[31];
  assign s2_neg    = signed_op & i_src2[31];
  assign abs1      = s1_neg ? (~i_src1 + 32'd1) : i_src1;
  assign abs2      = s2_neg ? (~i_src2 + 32'd1) : i_src2;
  assign div_zero  = (i_src2 == 32'd0);
  assign overflow  = signed_op && (i_src1 == 32'h8000_0000) && (i_src2 == 32'hFFFF_FFFF);

  // 33-bit shifted remainder so the trial-subtract borrow lands in bit 32.
  logic [32:0] shifted, trial;
  assign shifted = {rem_q, dvd_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    op_rem_d = op_rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_rem_d = i_op[1];
          dvd_d    = abs1;
          dvs_d    = abs2;
          negq_d   = s1_neg ^ s2_neg;
          negr_d   = s1_neg;
          rem_d    = 32'd0;
          cnt_d    = 5'd0;
          if (div_zero) begin
            result_d = i_op[1] ? i_src1 : 32'hFFFF_FFFF;
            state_d  = ST_DONE;
          end else if (overflow) begin
            result_d = i_op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = trial[32] ? shifted[31:0] : trial[31:0];
        dvd_d = {dvd_q[30:0], ~trial[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_rem_q) result_d = negr_q ? (~rem_q + 32'd1) : rem_q;
        else          result_d = negq_q ? (~dvd_q + 32'd1) : dvd_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything, including a same-cycle request or FIX load.
    if (i_flush) begin
      state_d  = ST_IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      op_rem_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      op_rem_q <= op_rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_div32b_iter.sv
// tb/tb_div32b_iter.sv - self-checking bench for div32b_iter
`timescale 1ns/1ps

module tb_div32b_iter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_src1 = 32'd0;
  logic [31:0] i_src2 = 32'd0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  div32b_iter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
    .i_op(i_op), .i_src1(i_src1), .i_src2(i_src2),
    .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  bit started = 1'b0;

  typedef struct { logic [31:0] res; int due; } exp_t;
  exp_t pend[$];

  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic (truncating division).
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Cycle-by-cycle compare against the model's view of accepted requests.
  always @(negedge i_clk) begin
    bit rdy, exp_valid;
    if (started) begin
      rdy = (pend.size() == 0);
      exp_valid = !rdy && (pend[0].due == cyc);
      chk("o_ready", {31'd0, o_ready}, {31'd0, rdy});
      chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("o_result", o_result, pend[0].res);
        void'(pend.pop_front());
      end
      if (i_rst || i_flush) begin
        pend.delete();
      end else if (i_valid && rdy) begin
        pend.push_back('{res: model(i_op, i_src1, i_src2), due: cyc + model_lat(i_op, i_src1, i_src2)});
        n_acc++;
      end
    end
  end

  // Issue one request at the current cycle, then wait for the pulse and check latency/result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    i_valid = 1'b1; i_op = op; i_src1 = a; i_src2 = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_op = 2'($urandom); i_src1 = $urandom; i_src2 = $urandom;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge i_clk);
      if (o_valid) break;
      @(posedge i_clk); #1;
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk(name, o_result, exp);
    @(posedge i_clk); #1;
  endtask

  initial begin
    int k;
    logic [31:0] a, b;
    int sel;
    @(posedge i_clk); #1;
    started = 1'b1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "div_m100_7");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, "rem_m100_7");
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, "div_100_m7");
    run_op(2'b10, 32'd7, 32'hFFFF_FF9C, 32'd7, 34, "rem_7_m100");
    run_op(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 34, "div_min_2");
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_by0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // Flush at cycle 10 of a DIVU; no pulse, ready in cycle 11.
    i_valid = 1'b1; i_op = 2'b01; i_src1 = 32'd1000; i_src2 = 32'd3;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) begin @(posedge i_clk); #1; end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_after_flush");

    // Flush together with a request in IDLE: request dropped.
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b01; i_src1 = 32'd9; i_src2 = 32'd3;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_ready", {31'd0, o_ready}, 32'd1);
    repeat (40) begin @(posedge i_clk); #1; end

    // Reset during CALC: back to reset outputs on the next edge, no pulse afterwards.
    i_valid = 1'b1; i_op = 2'b01; i_src1 = 32'd77; i_src2 = 32'd5;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (4) begin @(posedge i_clk); #1; end
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("calc_rst_ready", {31'd0, o_ready}, 32'd1);
    chk("calc_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("calc_rst_result", o_result, 32'd0);
    repeat (40) begin @(posedge i_clk); #1; end

    // Back-to-back random operations with i_valid held high.
    n_acc = 0;
    i_valid = 1'b1;
    for (k = 0; k < 60000 && n_acc < 1000; k++) begin
      sel = $urandom_range(0, 15);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 6) b = $urandom_range(1, 255);
      else if (sel < 8) a = $urandom_range(0, 1000);
      i_op = 2'($urandom); i_src1 = a; i_src2 = b;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("b2b_accepts", n_acc, 32'd1000);
    for (k = 0; k < 100 && pend.size() > 0; k++) begin @(posedge i_clk); #1; end
    chk("b2b_drained", pend.size(), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
